reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer.sv | 122 ++++++++++++
 tb/tb_reset_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronises an async reset and releases N_OUT
// downstream reset channels in a fixed, staggered order.
module reset_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int N_OUT       = 3,
    parameter int STRETCH     = 4,
    parameter int STAGGER     = 3
) (
    input  logic             _iClk,
    input  logic             _iReset,
    input  logic             _iSwReset,
    output logic [N_OUT-1:0] _oReset,
    output logic             _oResetDone
);

    localparam int MAXC = (STRETCH > STAGGER) ? STRETCH : STAGGER;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = $clog2(N_OUT + 1);

    typedef enum logic [1:0] {
        HOLD,
        RELEASE,
        DONE
    } stateT;

    logic [SYNC_STAGES-1:0] syncQ;
    logic                   syncRst;

    stateT             stateQ, stateN;
    logic [CW-1:0]     cntQ, cntN;
    logic [IW-1:0]     idxQ, idxN;
    logic [N_OUT-1:0]  rstQ, rstN;
    logic              doneQ, doneN;

    // Set on assertion, zeros ripple in from stage 0 once released
    always_ff @(posedge _iClk or posedge _iReset) begin
        if (_iReset) begin
            syncQ <= '1;
        end else begin
            syncQ <= {syncQ[SYNC_STAGES-2:0], 1'b0};
        end
    end

    assign syncRst = syncQ[SYNC_STAGES-1];

    always_ff @(posedge _iClk or posedge _iReset) begin
        if (_iReset) begin
            stateQ <= HOLD;
            cntQ   <= CW'(STRETCH);
            idxQ   <= '0;
            rstQ   <= '1;
            doneQ  <= 1'b0;
        end else begin
            stateQ <= stateN;
            cntQ   <= cntN;
            idxQ   <= idxN;
            rstQ   <= rstN;
            doneQ  <= doneN;
        end
    end

    always_comb begin
        stateN = stateQ;
        cntN   = cntQ;
        idxN   = idxQ;
        rstN   = rstQ;
        doneN  = doneQ;
        // Software reset outranks any release falling due on this edge
        if (syncRst || _iSwReset) begin
            stateN = HOLD;
            cntN   = CW'(STRETCH);
            idxN   = '0;
            rstN   = '1;
            doneN  = 1'b0;
        end else begin
            unique case (stateQ)
                HOLD: begin
                    if (cntQ == CW'(1)) begin
                        rstN[0] = 1'b0;
                        idxN    = IW'(1);
                        cntN    = CW'(STAGGER);
                        if (N_OUT == 1) begin
                            stateN = DONE;
                            doneN  = 1'b1;
                        end else begin
                            stateN = RELEASE;
                        end
                    end else begin
                        cntN = cntQ - CW'(1);
                    end
                end
                RELEASE: begin
                    if (cntQ == CW'(1)) begin
                        for (int k = 0; k < N_OUT; k++) begin
                            if (idxQ == IW'(k)) begin
                                rstN[k] = 1'b0;
                            end
                        end
                        idxN = idxQ + IW'(1);
                        cntN = CW'(STAGGER);
                        if (idxQ == IW'(N_OUT - 1)) begin
                            stateN = DONE;
                            doneN  = 1'b1;
                        end
                    end else begin
                        cntN = cntQ - CW'(1);
                    end
                end
                DONE: begin
                    stateN = DONE;
                end
                default: begin
                    stateN = HOLD;
                end
            endcase
        end
    end

    assign _oReset     = rstQ;
    assign _oResetDone = doneQ;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default build plus a
// single-channel build (SYNC_STAGES=3, STRETCH=1).
module tb_reset_sequencer;

    typedef struct {
        logic       sw;
        logic [2:0] expRst;
        logic       expDone;
        logic       expRst1;
        logic       expDone1;
    } vecT;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sw  = 1'b0;
    logic       sw1 = 1'b0;
    logic [2:0] oRst;
    logic       oDone;
    logic [0:0] oRst1;
    logic       oDone1;

    int checks = 0;
    int errors = 0;

    vecT tbl [26];

    always #5 clk = ~clk;

    reset_sequencer dut (
        ._iClk       (clk),
        ._iReset     (rst),
        ._iSwReset   (sw),
        ._oReset     (oRst),
        ._oResetDone (oDone)
    );

    reset_sequencer #(
        .SYNC_STAGES (3),
        .N_OUT       (1),
        .STRETCH     (1)
    ) dut1 (
        ._iClk       (clk),
        ._iReset     (rst),
        ._iSwReset   (sw1),
        ._oReset     (oRst1),
        ._oResetDone (oDone1)
    );

    task automatic check(input string name, input logic [3:0] act,
                         input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp,
                     $time);
        end
    endtask

    // d = edges since last edge the sequence restarted from
    function automatic logic [3:0] expSw(input int d);
        logic [2:0] r;
        for (int k = 0; k < 3; k++) r[k] = (d < 4 + 3 * k);
        return {r, (d >= 10)};
    endfunction

    function automatic logic [1:0] expOne(input int e);
        return {(e < 4), (e >= 4)};
    endfunction

    task automatic runEdges(input int from, input int upto);
        for (int e = from; e <= upto; e++) begin
            @(posedge clk);
            #1;
            check($sformatf("seq e%0d", e), {oRst, oDone}, expSw(e - 2));
            check($sformatf("one e%0d", e), {2'b00, oRst1, oDone1},
                  {2'b00, expOne(e)});
        end
    endtask

    task automatic pulseReset();
        #2 rst = 1'b1;
        #1;
        check("async assert", {oRst, oDone}, 4'b1110);
        check("async assert one", {2'b00, oRst1, oDone1}, 4'b0010);
        #2 rst = 1'b0;
    endtask

    initial begin
        tbl = '{
            '{1'b0, 3'b111, 1'b0, 1'b1, 1'b0},
            '{1'b0, 3'b111, 1'b0, 1'b1, 1'b0},
            '{1'b0, 3'b111, 1'b0, 1'b1, 1'b0},
            '{1'b0, 3'b111, 1'b0, 1'b0, 1'b1},
            '{1'b0, 3'b111, 1'b0, 1'b0, 1'b1},
            '{1'b0, 3'b110, 1'b0, 1'b0, 1'b1},
            '{1'b0, 3'b110, 1'b0, 1'b0, 1'b1},
            '{1'b0, 3'b110, 1'b0, 1'b0, 1'b1},
            '{1'b0, 3'b100, 1'b0, 1'b0, 1'b1},
            '{1'b0, 3'b100, 1'b0, 1'b0, 1'b1},
            '{1'b0, 3'b100, 1'b0, 1'b0, 1'b1},
            '{1'b0, 3'b000, 1'b1, 1'b0, 1'b1},
            '{1'b0, 3'b000, 1'b1, 1'b0, 1'b1},
            '{1'b1, 3'b111, 1'b0, 1'b0, 1'b1},
            '{1'b0, 3'b111, 1'b0, 1'b0, 1'b1},
            '{1'b0, 3'b111, 1'b0, 1'b0, 1'b1},
            '{1'b0, 3'b111, 1'b0, 1'b0, 1'b1},
            '{1'b0, 3'b110, 1'b0, 1'b0, 1'b1},
            '{1'b0, 3'b110, 1'b0, 1'b0, 1'b1},
            '{1'b0, 3'b110, 1'b0, 1'b0, 1'b1},
            '{1'b0, 3'b100, 1'b0, 1'b0, 1'b1},
            '{1'b0, 3'b100, 1'b0, 1'b0, 1'b1},
            '{1'b0, 3'b100, 1'b0, 1'b0, 1'b1},
            '{1'b0, 3'b000, 1'b1, 1'b0, 1'b1},
            '{1'b0, 3'b000, 1'b1, 1'b0, 1'b1},
            '{1'b0, 3'b000, 1'b1, 1'b0, 1'b1}
        };

        repeat (3) @(posedge clk);
        #1;
        check("reset state", {oRst, oDone}, 4'b1110);
        check("reset state one", {2'b00, oRst1, oDone1}, 4'b0010);
        @(negedge clk);
        rst = 1'b0;

        // Power-on sequence, then a one-cycle sw reset at edge 14
        for (int i = 0; i < 26; i++) begin
            sw = tbl[i].sw;
            @(posedge clk);
            #1;
            check($sformatf("tbl %0d", i + 1), {oRst, oDone},
                  {tbl[i].expRst, tbl[i].expDone});
            check($sformatf("tbl one %0d", i + 1),
                  {2'b00, oRst1, oDone1},
                  {2'b00, tbl[i].expRst1, tbl[i].expDone1});
        end

        // Sub-period pulse from DONE, then reassert between edges 7 and 8
        pulseReset();
        runEdges(1, 7);
        pulseReset();
        runEdges(1, 9);

        // sw held for three edges during RELEASE
        sw = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(posedge clk);
            #1;
            check($sformatf("sw hold %0d", j), {oRst, oDone}, 4'b1110);
        end
        sw = 1'b0;
        for (int d = 1; d <= 11; d++) begin
            @(posedge clk);
            #1;
            check($sformatf("sw restart d%0d", d), {oRst, oDone},
                  expSw(d));
        end

        // sw on the edge where channel 0 is due wins
        pulseReset();
        runEdges(1, 5);
        sw = 1'b1;
        @(posedge clk);
        #1;
        check("sw priority", {oRst, oDone}, 4'b1110);
        sw = 1'b0;
        for (int d = 1; d <= 10; d++) begin
            @(posedge clk);
            #1;
            check($sformatf("prio restart d%0d", d), {oRst, oDone},
                  expSw(d));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
